job_await_tracker: RTL and testbench

JOB_AWAIT_TRACKER -- requirements
Module: job_await_tracker

---
 rtl/job_await_pkg.sv | 12 +
 rtl/job_launch_ctr.sv | 38 +++
 rtl/job_await_tracker.sv | 159 +++++++++++++++
 tb/tb_job_await_tracker.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/job_await_pkg.sv
// Shared types for the job await tracker: controller states and the default batch size.
package job_await_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int NUM_JOBS_DEFAULT = 8;

endpackage

// File: rtl/job_launch_ctr.sv
// Offers job IDs 0..count-1 to the workers; launch_valid is registered and rises the cycle after start.
// A stalled ID holds until launch_ready; last_accept flags the handshake of ID count-1.
module job_launch_ctr #(
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ID_W:0]   count,
    input  logic            launch_ready,
    output logic            launch_valid,
    output logic [ID_W-1:0] launch_id,
    output logic            last_accept
);

    logic          accept;
    logic [ID_W:0] last_idx;

    assign accept      = launch_valid && launch_ready;
    assign last_idx    = count - (ID_W+1)'(1);
    assign last_accept = accept && ({1'b0, launch_id} == last_idx);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            launch_valid <= 1'b0;
            launch_id    <= '0;
        end else if (start) begin
            launch_valid <= 1'b1;
            launch_id    <= '0;
        end else if (accept) begin
            launch_valid <= !last_accept;
            if (!last_accept) begin
                launch_id <= launch_id + ID_W'(1);
            end
        end
    end

endmodule

// File: rtl/job_await_tracker.sv
// Batch job tracker: launches IDs, records start/done reports, resolves single-job awaits.
// Status/err/await_done are registered (one cycle after the event); all_done is decoded from state.
module job_await_tracker
    import job_await_pkg::*;
#(
    parameter int NUM_JOBS = NUM_JOBS_DEFAULT,
    parameter int ID_W     = $clog2(NUM_JOBS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            spawn_valid,
    output logic            spawn_ready,
    input  logic [ID_W:0]   spawn_count,
    output logic            launch_valid,
    input  logic            launch_ready,
    output logic [ID_W-1:0] launch_id,
    input  logic            reg_valid,
    input  logic [ID_W-1:0] reg_id,
    input  logic            done_valid,
    input  logic [ID_W-1:0] done_id,
    input  logic            await_valid,
    input  logic [ID_W-1:0] await_id,
    output logic            await_ready,
    output logic            await_done,
    output logic            all_started,
    output logic            all_done,
    output logic            busy,
    output logic            err
);

    localparam int VEC_W = 1 << ID_W;

    state_t           state, state_d;
    logic [ID_W:0]    count, count_d;
    logic [VEC_W-1:0] started, started_d, done_vec, done_d, mask, mask_d;
    logic             spawn_fire, spawn_ok, spawn_bad;
    logic             reg_ok, reg_bad, done_ok, done_bad;
    logic             await_hs, await_take, await_bad, await_fire;
    logic             pend, pend_nx, eff_pend;
    logic [ID_W-1:0]  pend_id, eff_id;
    logic             last_accept, run_done, all_started_d;

    assign spawn_fire = spawn_valid && (state == ST_IDLE);
    assign spawn_ok   = spawn_fire && (spawn_count != '0) &&
                        (spawn_count <= (ID_W+1)'(NUM_JOBS));
    assign spawn_bad  = spawn_fire && !spawn_ok;
    assign count_d    = spawn_ok ? spawn_count : count;

    assign reg_ok  = reg_valid && (state != ST_IDLE) &&
                     ({1'b0, reg_id} < count) && !started[reg_id];
    assign reg_bad = reg_valid && !reg_ok;

    always_comb begin
        started_d = started;
        if (spawn_ok) begin
            started_d = '0;
        end else if (reg_ok) begin
            started_d[reg_id] = 1'b1;
        end
    end

    // started_d already includes a same-cycle reg, so reg+done of one ID both land
    assign done_ok  = done_valid && ({1'b0, done_id} < count) &&
                      started_d[done_id] && !done_vec[done_id];
    assign done_bad = done_valid && !done_ok;

    always_comb begin
        done_d = done_vec;
        if (spawn_ok) begin
            done_d = '0;
        end else if (done_ok) begin
            done_d[done_id] = 1'b1;
        end
    end

    always_comb begin
        mask   = '0;
        mask_d = '0;
        for (int i = 0; i < VEC_W; i++) begin
            mask[i]   = (i < int'(count));
            mask_d[i] = (i < int'(count_d));
        end
    end

    assign run_done      = (state == ST_RUN) && ((done_vec & mask) == mask);
    assign all_started_d = (state_d != ST_IDLE) && ((started_d & mask_d) == mask_d);

    // An accepted await resolves against done_d, covering both already-done and same-cycle done
    assign await_ready = !pend;
    assign await_hs    = await_valid && !pend;
    assign await_bad   = await_hs && ({1'b0, await_id} >= count);
    assign await_take  = await_hs && !await_bad;
    assign eff_pend    = pend || await_take;
    assign eff_id      = pend ? pend_id : await_id;
    assign await_fire  = eff_pend && done_d[eff_id] && !spawn_ok;
    assign pend_nx     = eff_pend && !await_fire && !spawn_ok;

    job_launch_ctr #(
        .ID_W(ID_W)
    ) u_launch (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (spawn_ok),
        .count        (count),
        .launch_ready (launch_ready),
        .launch_valid (launch_valid),
        .launch_id    (launch_id),
        .last_accept  (last_accept)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (spawn_ok)    state_d = ST_LAUNCH;
            ST_LAUNCH: if (last_accept) state_d = ST_RUN;
            ST_RUN:    if (run_done)    state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        spawn_ready = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        all_done    = run_done;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            started     <= '0;
            done_vec    <= '0;
            pend        <= 1'b0;
            pend_id     <= '0;
            all_started <= 1'b0;
            await_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            count       <= count_d;
            started     <= started_d;
            done_vec    <= done_d;
            pend        <= pend_nx;
            if (await_take) begin
                pend_id <= await_id;
            end
            all_started <= all_started_d;
            await_done  <= await_fire;
            err         <= spawn_bad || reg_bad || done_bad || await_bad;
        end
    end

endmodule

// File: tb/tb_job_await_tracker.sv
// Directed scenarios then random traffic, every cycle compared against a queue/array reference model.
module tb_job_await_tracker;

    localparam int NJ = 8;
    localparam int IW = 4;
    localparam int VW = 1 << IW;

    logic          clk = 1'b0;
    logic          rst_n, spawn_valid, spawn_ready, launch_valid, launch_ready;
    logic [IW:0]   spawn_count;
    logic [IW-1:0] launch_id, reg_id, done_id, await_id;
    logic          reg_valid, done_valid, await_valid, await_ready, await_done;
    logic          all_started, all_done, busy, err;

    always #5 clk = ~clk;

    job_await_tracker #(.NUM_JOBS(NJ), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_count(spawn_count),
        .launch_valid(launch_valid), .launch_ready(launch_ready), .launch_id(launch_id),
        .reg_valid(reg_valid), .reg_id(reg_id), .done_valid(done_valid), .done_id(done_id),
        .await_valid(await_valid), .await_id(await_id), .await_ready(await_ready),
        .await_done(await_done), .all_started(all_started), .all_done(all_done),
        .busy(busy), .err(err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: batch membership as arrays, pending launches as a queue of IDs
    bit            m_busy, m_pend, m_err, m_adone, m_allst;
    int            m_count, m_lid;
    logic [IW-1:0] m_pid;
    bit            m_started[VW];
    bit            m_done[VW];
    int            m_q[$];

    function automatic bit all_set(input bit v[VW], input int cnt);
        foreach (v[i]) if (i < cnt && !v[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ns[VW];
        bit nd[VW];
        bit e, ad, sok, fin, has_tgt;
        logic [IW-1:0] tgt;
        if (!rst_n) begin
            m_busy = 0; m_pend = 0; m_err = 0; m_adone = 0; m_allst = 0;
            m_count = 0; m_lid = 0; m_pid = '0;
            m_q.delete();
            foreach (m_started[i]) begin m_started[i] = 0; m_done[i] = 0; end
            return;
        end
        e = 0; ad = 0; sok = 0; has_tgt = 0; tgt = '0;
        if (spawn_valid && !m_busy) begin
            if (spawn_count >= 1 && spawn_count <= NJ) sok = 1; else e = 1;
        end
        fin = m_busy && m_q.size() == 0 && all_set(m_done, m_count);
        ns = m_started;
        nd = m_done;
        if (sok) foreach (ns[i]) begin ns[i] = 0; nd[i] = 0; end
        if (reg_valid) begin
            if (m_busy && reg_id < m_count && !m_started[reg_id]) ns[reg_id] = 1;
            else e = 1;
        end
        if (done_valid) begin
            if (done_id < m_count && ns[done_id] && !m_done[done_id]) nd[done_id] = 1;
            else e = 1;
        end
        if (m_pend) begin
            has_tgt = 1; tgt = m_pid;
        end else if (await_valid) begin
            if (await_id >= m_count) e = 1;
            else begin has_tgt = 1; tgt = await_id; end
        end
        if (sok) m_pend = 0;
        else if (has_tgt) begin
            if (nd[tgt]) begin ad = 1; m_pend = 0; end
            else begin m_pend = 1; m_pid = tgt; end
        end
        if (m_q.size() > 0 && launch_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() > 0) m_lid = m_q[0];
        end
        if (sok) begin
            m_q.delete();
            for (int i = 0; i < int'(spawn_count); i++) m_q.push_back(i);
            m_count = int'(spawn_count);
            m_busy = 1;
            m_lid = 0;
        end
        if (fin) m_busy = 0;
        m_started = ns;
        m_done = nd;
        m_err = e;
        m_adone = ad;
        m_allst = m_busy && all_set(ns, m_count);
    endtask

    task automatic check_outputs();
        chk("spawn_ready", spawn_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("launch_valid", launch_valid, m_q.size() > 0);
        chk("launch_id", launch_id, m_lid);
        chk("await_ready", await_ready, !m_pend);
        chk("await_done", await_done, m_adone);
        chk("all_started", all_started, m_allst);
        chk("all_done", all_done, m_busy && m_q.size() == 0 && all_set(m_done, m_count));
        chk("err", err, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n = 0; spawn_valid = 0; spawn_count = '0; launch_ready = 0;
        reg_valid = 0; reg_id = '0; done_valid = 0; done_id = '0;
        await_valid = 0; await_id = '0;
        tick();
        tick();
        chk("rst_spawn_ready", spawn_ready, 1);
        chk("rst_await_ready", await_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_launch_valid", launch_valid, 0);
        rst_n = 1;

        // Eight-job batch, workers always ready
        launch_ready = 1; spawn_valid = 1; spawn_count = 8;
        tick();
        spawn_valid = 0;
        for (int i = 0; i < 8; i++) begin
            chk("seq_launch_valid", launch_valid, 1);
            chk("seq_launch_id", launch_id, i);
            tick();
        end
        chk("seq_launch_end", launch_valid, 0);
        chk("seq_run_busy", busy, 1);

        for (int i = 0; i < 5; i++) begin reg_valid = 1; reg_id = IW'(i); tick(); end
        reg_id = 3; tick();
        chk("dup_reg_err", err, 1);
        reg_valid = 0; done_valid = 1; done_id = 5; tick();
        chk("early_done_err", err, 1);
        done_valid = 0; tick();
        chk("err_single_cycle", err, 0);
        reg_valid = 1; reg_id = 9; tick();
        chk("reg_range_err", err, 1);
        for (int i = 5; i < 8; i++) begin
            chk("all_started_early", all_started, 0);
            reg_id = IW'(i);
            tick();
        end
        reg_valid = 0;
        chk("all_started_set", all_started, 1);

        await_valid = 1; await_id = 1; tick();
        await_valid = 0;
        chk("await_pending", await_ready, 0);
        done_valid = 1;
        for (int i = 7; i >= 1; i--) begin
            done_id = IW'(i);
            tick();
            chk("await_timing", await_done, i == 1);
        end
        done_id = 0; tick();
        done_valid = 0;
        chk("await_one_pulse", await_done, 0);
        chk("all_done_pulse", all_done, 1);
        tick();
        chk("all_done_end", all_done, 0);
        chk("batch_idle", busy, 0);
        chk("all_started_drop", all_started, 0);
        await_valid = 1; await_id = 1; tick();
        await_valid = 0;
        chk("await_already_done", await_done, 1);
        spawn_valid = 1; spawn_count = 0; tick();
        chk("spawn_zero_err", err, 1);
        chk("spawn_zero_idle", busy, 0);
        spawn_count = 9; tick();
        spawn_valid = 0;
        chk("spawn_big_err", err, 1);

        // Four-job batch with a two-cycle stall on ID 1
        spawn_valid = 1; spawn_count = 4; launch_ready = 1; tick();
        spawn_valid = 0;
        chk("stall_id0", launch_id, 0);
        tick();
        chk("stall_id1_a", launch_id, 1);
        launch_ready = 0; tick();
        chk("stall_id1_b", launch_id, 1);
        tick();
        chk("stall_id1_c", launch_id, 1);
        launch_ready = 1; tick();
        chk("stall_id2", launch_id, 2);
        tick();
        chk("stall_id3", launch_id, 3);
        tick();
        chk("stall_done_launch", launch_valid, 0);

        // Reset mid-RUN with three jobs done, then a fresh two-job batch
        reg_valid = 1;
        for (int i = 0; i < 4; i++) begin reg_id = IW'(i); tick(); end
        reg_valid = 0; done_valid = 1;
        for (int i = 0; i < 3; i++) begin done_id = IW'(i); tick(); end
        done_valid = 0; rst_n = 0; tick();
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_started", all_started, 0);
        rst_n = 1; await_valid = 1; await_id = 0; tick();
        await_valid = 0;
        chk("rst_count_cleared", err, 1);
        spawn_valid = 1; spawn_count = 2; tick();
        spawn_valid = 0;
        tick();
        tick();
        reg_valid = 1;
        for (int i = 0; i < 2; i++) begin reg_id = IW'(i); tick(); end
        reg_valid = 0; done_valid = 1;
        for (int i = 0; i < 2; i++) begin done_id = IW'(i); tick(); end
        done_valid = 0;
        chk("post_rst_all_done", all_done, 1);
        tick();
        chk("post_rst_idle", busy, 0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            rst_n        = ($urandom_range(0, 299) != 0);
            spawn_valid  = ($urandom_range(0, 3) == 0);
            spawn_count  = (IW+1)'($urandom_range(0, 9));
            launch_ready = ($urandom_range(0, 3) != 0);
            reg_valid    = ($urandom_range(0, 1) == 1);
            reg_id       = IW'($urandom_range(0, 9));
            done_valid   = ($urandom_range(0, 1) == 1);
            done_id      = IW'($urandom_range(0, 9));
            await_valid  = ($urandom_range(0, 3) == 0);
            await_id     = IW'($urandom_range(0, 9));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
